// File: rtl/redutor_de_sinal_pkg.sv
// redutor_de_sinal_pkg
// Shared constants for the immediate-narrowing path: the modo encoding and
// the derivation of the signed output range limits from the output width.
// Used by redutor_de_sinal_nucleo and any other immediate datapath that needs
// the same MIN/MAX definition.
package redutor_de_sinal_pkg;

  // Narrowing behaviour when the input does not fit the output width.
  typedef enum logic {
    SATURAR = 1'b0,
    TRUNCAR = 1'b1
  } modo_e;

  // Largest representable value of a signed word of the given width: 2^(w-1)-1.
  function automatic logic signed [31:0] limite_max(input int unsigned largura);
    limite_max = (32'sd1 <<< (largura - 32'd1)) - 32'sd1;
  endfunction

  // Smallest representable value of a signed word of the given width: -2^(w-1).
  function automatic logic signed [31:0] limite_min(input int unsigned largura);
    limite_min = -(32'sd1 <<< (largura - 32'd1));
  endfunction

endpackage

// File: rtl/redutor_de_sinal_nucleo.sv
// redutor_de_sinal_nucleo
// Combinational range check and narrowing of a signed word.
// Ports:
//   entrada   [LARGURA_ENTRADA-1:0] signed input value
//   modo      0 = saturate, 1 = wrap (keep low bits)
//   resultado [LARGURA_SAIDA-1:0]   narrowed signed value
//   estouro   input lies outside the signed output range
module redutor_de_sinal_nucleo
  import redutor_de_sinal_pkg::*;
#(
  parameter int LARGURA_ENTRADA = 8,
  parameter int LARGURA_SAIDA   = 5
) (
  input  logic [LARGURA_ENTRADA-1:0] entrada,
  input  logic                       modo,
  output logic [LARGURA_SAIDA-1:0]   resultado,
  output logic                       estouro
);

  localparam logic [LARGURA_SAIDA-1:0] MAX_C = LARGURA_SAIDA'(limite_max(LARGURA_SAIDA));
  localparam logic [LARGURA_SAIDA-1:0] MIN_C = LARGURA_SAIDA'(limite_min(LARGURA_SAIDA));

  // The value fits exactly when every bit from the output sign bit upward
  // is a copy of the input sign, i.e. the discarded bits are pure sign extension.
  logic [LARGURA_ENTRADA-LARGURA_SAIDA:0] topo_s;
  logic                                   dentro_s;

  assign topo_s   = entrada[LARGURA_ENTRADA-1:LARGURA_SAIDA-1];
  assign dentro_s = (&topo_s) | ~(|topo_s);

  // Range check and selection of the narrowed value.
  always_comb begin
    resultado = entrada[LARGURA_SAIDA-1:0];
    estouro   = 1'b0;
    if (dentro_s) begin
      resultado = entrada[LARGURA_SAIDA-1:0];
      estouro   = 1'b0;
    end else begin
      estouro = 1'b1;
      case (modo_e'(modo))
        SATURAR: resultado = entrada[LARGURA_ENTRADA-1] ? MIN_C : MAX_C;
        TRUNCAR: resultado = entrada[LARGURA_SAIDA-1:0];
        default: resultado = entrada[LARGURA_SAIDA-1:0];
      endcase
    end
  end

endmodule

// File: rtl/redutor_de_sinal.sv
// redutor_de_sinal
// Two-stage valid/ready pipeline that narrows a signed word to a smaller
// signed immediate (saturate or wrap) and counts out-of-range deliveries.
// Ports:
//   Clock, Reset              rising-edge clock, synchronous active-high reset
//   Entrada, modo             input word and narrowing mode (0 sat, 1 wrap)
//   in_valid / in_ready       upstream handshake
//   Resultado, estouro        narrowed value and out-of-range flag
//   out_valid / out_ready     downstream handshake
//   limpar                    synchronous clear of contador_estouros
//   contador_estouros         saturating count of delivered out-of-range words
module redutor_de_sinal
  import redutor_de_sinal_pkg::*;
#(
  parameter int LARGURA_ENTRADA = 8,
  parameter int LARGURA_SAIDA   = 5
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic [LARGURA_ENTRADA-1:0] Entrada,
  input  logic                       modo,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [LARGURA_SAIDA-1:0]   Resultado,
  output logic                       estouro,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic                       limpar,
  output logic [7:0]                 contador_estouros
);

  logic                       s1_valid_r;
  logic [LARGURA_ENTRADA-1:0] s1_entrada_r;
  logic                       s1_modo_r;
  logic                       s2_valid_r;
  logic [LARGURA_SAIDA-1:0]   s2_resultado_r;
  logic                       s2_estouro_r;
  logic [7:0]                 contador_r;

  logic [LARGURA_SAIDA-1:0]   nucleo_resultado_s;
  logic                       nucleo_estouro_s;
  logic                       s2_livre_s;
  logic                       s1_livre_s;
  logic                       transf_saida_s;

  // A stage may load when it is empty or its word leaves at this same edge.
  assign s2_livre_s     = !s2_valid_r || out_ready;
  assign s1_livre_s     = !s1_valid_r || s2_livre_s;
  assign transf_saida_s = s2_valid_r && out_ready;

  assign in_ready          = s1_livre_s;
  assign out_valid         = s2_valid_r;
  assign Resultado         = s2_resultado_r;
  assign estouro           = s2_estouro_r;
  assign contador_estouros = contador_r;

  redutor_de_sinal_nucleo #(
    .LARGURA_ENTRADA(LARGURA_ENTRADA),
    .LARGURA_SAIDA  (LARGURA_SAIDA)
  ) u_nucleo (
    .entrada  (s1_entrada_r),
    .modo     (s1_modo_r),
    .resultado(nucleo_resultado_s),
    .estouro  (nucleo_estouro_s)
  );

  // Stage 1: captures the raw input word and its mode.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      s1_valid_r   <= 1'b0;
      s1_entrada_r <= {LARGURA_ENTRADA{1'b0}};
      s1_modo_r    <= 1'b0;
    end else if (s1_livre_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_entrada_r <= Entrada;
        s1_modo_r    <= modo;
      end
    end
  end

  // Stage 2: captures the narrowed result; holds it while downstream stalls.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      s2_valid_r     <= 1'b0;
      s2_resultado_r <= {LARGURA_SAIDA{1'b0}};
      s2_estouro_r   <= 1'b0;
    end else if (s2_livre_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_resultado_r <= nucleo_resultado_s;
        s2_estouro_r   <= nucleo_estouro_s;
      end
    end
  end

  // Overflow counter: clear wins over increment, sticks at 255.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      contador_r <= 8'd0;
    end else if (limpar) begin
      contador_r <= 8'd0;
    end else if (transf_saida_s && s2_estouro_r && (contador_r != 8'hFF)) begin
      contador_r <= contador_r + 8'd1;
    end
  end

endmodule

// File: tb/tb_redutor_de_sinal.sv
// Self-checking bench for redutor_de_sinal (default 8 -> 5 bits).
module tb_redutor_de_sinal;

  logic       Clock;
  logic       Reset;
  logic [7:0] Entrada;
  logic       modo;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] Resultado;
  logic       estouro;
  logic       out_valid;
  logic       out_ready;
  logic       limpar;
  logic [7:0] contador_estouros;

  redutor_de_sinal #(
    .LARGURA_ENTRADA(8),
    .LARGURA_SAIDA  (5)
  ) dut (
    .Clock            (Clock),
    .Reset            (Reset),
    .Entrada          (Entrada),
    .modo             (modo),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .Resultado        (Resultado),
    .estouro          (estouro),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .limpar           (limpar),
    .contador_estouros(contador_estouros)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [4:0] r;
    logic       e;
    logic [7:0] ent;
    logic       ext;
  } sb_t;

  typedef struct {
    logic [7:0] ent;
    logic       m;
    logic [4:0] r;
    logic       e;
  } vec_t;

  sb_t  sb_q[$];
  vec_t tab[12];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Drive one word and hold it until accepted; the expected result is queued at acceptance.
  task automatic send(input logic [7:0] e, input logic m, input logic [4:0] r, input logic est,
                      input logic ext);
    logic acc;
    sb_t  it;
    acc = 1'b0;
    in_valid = 1'b1;
    Entrada  = e;
    modo     = m;
    for (int t = 0; t < 200; t++) begin
      @(negedge Clock);
      acc = in_ready;
      if (acc) begin
        it.r = r; it.e = est; it.ent = e; it.ext = ext;
        sb_q.push_back(it);
      end
      @(posedge Clock);
      #1;
      if (acc) break;
    end
    if (!acc) chk("send_timeout", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 50 && sb_q.size() != 0; t++) @(posedge Clock);
    #1;
    chk("drain_empty", sb_q.size(), 0);
  endtask

  // Scoreboard and overflow-counter model, evaluated for the upcoming edge.
  always @(negedge Clock) begin
    sb_t  it;
    logic tr_est;
    tr_est = 1'b0;
    if (Reset) begin
      sb_q.delete();
      exp_cnt = 0;
    end else begin
      chk("contador", contador_estouros, exp_cnt);
      if (out_valid && out_ready) begin
        chk("sb_word_expected", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          it = sb_q.pop_front();
          chk("resultado", Resultado, it.r);
          chk("estouro", estouro, it.e);
          if (it.ext) chk("sign_ext", {{3{Resultado[4]}}, Resultado}, it.ent);
          tr_est = it.e;
        end
      end
      if (limpar) exp_cnt = 0;
      else if (out_valid && out_ready && tr_est && exp_cnt < 255) exp_cnt++;
    end
  end

  initial begin
    tab[0]  = '{8'h64, 1'b0, 5'b01111, 1'b1};
    tab[1]  = '{8'h80, 1'b0, 5'b10000, 1'b1};
    tab[2]  = '{8'h80, 1'b1, 5'b00000, 1'b1};
    tab[3]  = '{8'h10, 1'b0, 5'b01111, 1'b1};
    tab[4]  = '{8'h10, 1'b1, 5'b10000, 1'b1};
    tab[5]  = '{8'hEF, 1'b0, 5'b10000, 1'b1};
    tab[6]  = '{8'hEF, 1'b1, 5'b01111, 1'b1};
    tab[7]  = '{8'h0F, 1'b0, 5'b01111, 1'b0};
    tab[8]  = '{8'hF0, 1'b1, 5'b10000, 1'b0};
    tab[9]  = '{8'h7F, 1'b1, 5'b11111, 1'b1};
    tab[10] = '{8'h7F, 1'b0, 5'b01111, 1'b1};
    tab[11] = '{8'h00, 1'b0, 5'b00000, 1'b0};

    Reset = 1'b1; Entrada = 8'h00; modo = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1; limpar = 1'b0;
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_resultado", Resultado, 0);
    chk("rst_estouro", estouro, 0);
    chk("rst_contador", contador_estouros, 0);

    // First word: latency and counter timing.
    send(8'h64, 1'b0, 5'b01111, 1'b1, 1'b0);
    chk("lat_not_yet", out_valid, 0);
    @(posedge Clock); #1;
    chk("lat_out_valid", out_valid, 1);
    chk("lat_resultado", Resultado, 5'b01111);
    chk("lat_estouro", estouro, 1);
    @(posedge Clock); #1;
    chk("lat_contador", contador_estouros, 8'd1);

    // Table vectors streamed back to back.
    for (int i = 0; i < 12; i++) send(tab[i].ent, tab[i].m, tab[i].r, tab[i].e, 1'b0);
    drain();

    // In-range sweep, both modes.
    for (int m = 0; m < 2; m++)
      for (int v = -16; v <= 15; v++)
        send(8'(v), 1'(m), 5'(v), 1'b0, 1'b1);
    drain();

    // Backpressure: out_ready low for 4 edges while streaming 0..9.
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) send(8'(i), 1'b0, 5'(i), 1'b0, 1'b0);
      end
      begin
        repeat (2) @(posedge Clock);
        #2;
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_resultado", Resultado, 5'd0);
        repeat (2) begin
          @(posedge Clock); #2;
          chk("bp_hold_resultado", Resultado, 5'd0);
          chk("bp_hold_estouro", estouro, 0);
          chk("bp_hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Counter saturation, then clear coinciding with an overflow transfer.
    for (int i = 0; i < 260; i++) send(8'h40, 1'b0, 5'b01111, 1'b1, 1'b0);
    drain();
    repeat (2) @(posedge Clock); #1;
    chk("sat_contador", contador_estouros, 8'd255);
    send(8'h40, 1'b0, 5'b01111, 1'b1, 1'b0);
    @(posedge Clock); #1;
    chk("clr_transfer_pending", out_valid, 1);
    limpar = 1'b1;
    @(posedge Clock); #1;
    limpar = 1'b0;
    chk("clr_contador", contador_estouros, 8'd0);

    // Reset with both stages full and a coincident handshake.
    send(8'hC0, 1'b0, 5'b10000, 1'b1, 1'b0);
    drain();
    repeat (2) @(posedge Clock); #1;
    chk("pre_rst_contador", contador_estouros, 8'd1);
    out_ready = 1'b0;
    send(8'h01, 1'b0, 5'd1, 1'b0, 1'b0);
    send(8'h02, 1'b0, 5'd2, 1'b0, 1'b0);
    chk("full_in_ready", in_ready, 0);
    Reset = 1'b1; in_valid = 1'b1; Entrada = 8'h33; modo = 1'b0;
    @(posedge Clock); #1;
    Reset = 1'b0; in_valid = 1'b0;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_contador", contador_estouros, 8'd0);
    chk("mid_rst_resultado", Resultado, 5'd0);
    out_ready = 1'b1;
    repeat (6) @(posedge Clock); #1;
    chk("no_stale_out_valid", out_valid, 0);
    chk("final_sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
